uart_pkt_sched: RTL and testbench

UART_PKT_SCHED -- requirements
Module: uart_pkt_sched

---
 rtl/uart_pkt_sched.sv | 154 +++++++++++++++
 tb/tb_uart_pkt_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_sched.sv
// uart_pkt_sched -- packetises 16-bit samples from two channels into 5-byte
// UART packets: HEADER, channel id, data[15:8], data[7:0], XOR checksum.
// Channels are granted round-robin. Each byte is handed to the transmitter
// with a one-cycle tx_start pulse. The byte is resent if tx_busy never rises.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (release synchronised internally)
//   s0_valid/s0_data/s0_ready   channel 0 (filtered sample) handshake
//   s1_valid/s1_data/s1_ready   channel 1 (raw sample) handshake
//   tx_start   one-cycle start pulse to the UART transmitter
//   tx_data    byte for the transmitter, held between pulses
//   tx_busy    busy flag from the transmitter
//   busy       packet in progress
//   pkt_count  completed packets, wraps at 2^16
//
// state   | meaning
// IDLE    | waiting for a sample handshake
// SEND    | tx_start high for one cycle with the current byte
// WAIT_HI | waiting for tx_busy to rise, resend after 4 cycles without it
// WAIT_LO | waiting for tx_busy to fall, then next byte or packet done
module uart_pkt_sched #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_valid,
  input  logic [15:0] s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [15:0] s1_data,
  output logic        s1_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        busy,
  output logic [15:0] pkt_count
);

  localparam int         NUM_BYTES = 5;
  localparam logic [2:0] LAST_IDX  = 3'(NUM_BYTES - 1);
  // Loaded on the pulse cycle; the resend happens on the 5th cycle after it.
  localparam logic [1:0] TMO_LOAD  = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t      state;
  logic [1:0]  rst_sync;
  logic        run;
  logic        last_grant;
  logic        grant;
  logic        hs;
  logic [15:0] sel_data;
  logic [7:0]  sel_id;
  logic [2:0]  idx;
  logic [1:0]  tmo;
  logic        cap_ch;
  logic [7:0]  cap_hi;
  logic [7:0]  cap_lo;
  logic [7:0]  cap_chk;

  // Reset assertion is asynchronous; release reaches the FSM two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  always_comb begin
    grant = 1'b0;
    if (s0_valid && s1_valid) grant = ~last_grant;
    else if (s1_valid)        grant = 1'b1;
  end

  assign s0_ready = run && (state == IDLE) && s0_valid && !grant;
  assign s1_ready = run && (state == IDLE) && s1_valid && grant;
  assign hs       = s0_ready || s1_ready;
  assign sel_data = grant ? s1_data : s0_data;
  assign sel_id   = {7'd0, grant};
  assign busy     = (state != IDLE);

  function automatic logic [7:0] pkt_byte(input logic [2:0] i);
    case (i)
      3'd0:    pkt_byte = HEADER;
      3'd1:    pkt_byte = {7'd0, cap_ch};
      3'd2:    pkt_byte = cap_hi;
      3'd3:    pkt_byte = cap_lo;
      default: pkt_byte = cap_chk;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      last_grant <= 1'b1;
      tmo        <= 2'd0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      pkt_count  <= 16'd0;
      cap_ch     <= 1'b0;
      cap_hi     <= 8'h00;
      cap_lo     <= 8'h00;
      cap_chk    <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            cap_ch     <= grant;
            cap_hi     <= sel_data[15:8];
            cap_lo     <= sel_data[7:0];
            cap_chk    <= HEADER ^ sel_id ^ sel_data[15:8] ^ sel_data[7:0];
            last_grant <= grant;
            idx        <= 3'd0;
            // tx_start is raised on entry so the pulse coincides with SEND.
            tx_data    <= HEADER;
            tx_start   <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          tmo   <= TMO_LOAD;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (tmo == 2'd0) begin
            tx_start <= 1'b1;
            state    <= SEND;
          end else begin
            tmo <= tmo - 2'd1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (idx == LAST_IDX) begin
              pkt_count <= pkt_count + 16'd1;
              state     <= IDLE;
            end else begin
              idx      <= idx + 3'd1;
              tx_data  <= pkt_byte(idx + 3'd1);
              tx_start <= 1'b1;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_sched.sv
// Testbench for uart_pkt_sched: drives directed samples, models a UART
// transmitter (busy one cycle after start, 10-bit frame at one clock per
// bit), decodes the serial line, and compares against hand-built packets.
module tb_uart_pkt_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_valid, s1_valid;
  logic [15:0] s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic [15:0] pkt_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_pkt_sched dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .pkt_count(pkt_count)
  );

  // UART transmitter model
  logic       model_en = 1'b1;
  logic [9:0] frame = 10'h3FF;
  int         bit_cnt = 0;
  logic       tx_line;
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (model_en && bit_cnt == 0 && tx_start) begin
      frame   <= {1'b1, tx_data, 1'b0};
      bit_cnt <= 10;
      tx_busy <= 1'b1;
      sent_q.push_back(tx_data);
    end else if (bit_cnt > 0) begin
      frame   <= {1'b1, frame[9:1]};
      bit_cnt <= bit_cnt - 1;
      if (bit_cnt == 1) tx_busy <= 1'b0;
    end
  end
  assign tx_line = (bit_cnt > 0) ? frame[0] : 1'b1;

  // Serial line decoder, samples mid-bit on the falling edge
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  always @(negedge clk) begin
    if (rx_cnt == 0) begin
      if (!tx_line) rx_cnt <= 1;
    end else if (rx_cnt <= 8) begin
      rx_sh  <= {tx_line, rx_sh[7:1]};
      rx_cnt <= rx_cnt + 1;
    end else begin
      if (tx_line) rx_q.push_back(rx_sh);
      rx_cnt <= 0;
    end
  end

  // Protocol monitor
  logic prev_start = 1'b0;
  int   proto_err = 0;
  always @(negedge clk) begin
    if (tx_start && tx_busy)    proto_err++;
    if (tx_start && prev_start) proto_err++;
    if (s0_ready && s1_ready)   proto_err++;
    prev_start <= tx_start;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input logic ch, input logic [15:0] d);
    logic [7:0] b1;
    b1 = {7'd0, ch};
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(8'hA5 ^ b1 ^ d[15:8] ^ d[7:0]);
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_n"}, sent_q.size(), exp_q.size());
    chk({tag, "_rx_n"}, rx_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < sent_q.size()) chk($sformatf("%s_b%0d", tag, i), sent_q[i], exp_q[i]);
      if (i < rx_q.size())   chk($sformatf("%s_rx%0d", tag, i), rx_q[i], exp_q[i]);
    end
  endtask

  task automatic wait_pkts(input string tag, input logic [15:0] n, input int budget);
    int cyc = 0;
    while (pkt_count != n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, pkt_count, n);
  endtask

  // Holds reset long enough for the transmitter model to go idle, clears the
  // byte logs, releases reset and returns on the cycle where a handshake can
  // first be granted (it lands on the 3rd rising edge after release).
  task automatic do_reset();
    reset = 1'b0;
    repeat (15) @(negedge clk);
    sent_q.delete();
    rx_q.delete();
    exp_q.delete();
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    s0_valid = 1'b1; s0_data = 16'h1234;
    s1_valid = 1'b0; s1_data = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s0_ready", s0_ready, 0);

    // Release synchronisation and first-handshake latency
    reset = 1'b1;
    @(negedge clk);
    chk("sync_e1_ready", s0_ready, 0);
    @(negedge clk);
    chk("sync_e2_ready", s0_ready, 1);
    chk("sync_e2_start", tx_start, 0);
    @(negedge clk);
    chk("lat_start", tx_start, 1);
    chk("lat_data", tx_data, 8'hA5);
    chk("lat_busy", busy, 1);
    s0_valid = 1'b0;
    s0_data  = 16'hFFFF;

    // Single packet
    wait_pkts("single_done", 16'd1, 400);
    push_pkt(1'b0, 16'h1234);
    cmp_bytes("single");
    @(negedge clk);
    chk("single_idle", busy, 0);

    // Contention, round-robin from channel 0
    do_reset();
    s0_data = 16'h0001; s1_data = 16'h0002;
    s0_valid = 1'b1; s1_valid = 1'b1;
    wait_pkts("cont_p1", 16'd1, 400);
    chk("b2b_s1_ready", s1_ready, 1);
    chk("b2b_s0_ready", s0_ready, 0);
    @(negedge clk);
    chk("b2b_start", tx_start, 1);
    chk("b2b_data", tx_data, 8'hA5);
    wait_pkts("cont_p4", 16'd4, 1500);
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    chk("cont_idle", busy, 0);
    push_pkt(1'b0, 16'h0001);
    push_pkt(1'b1, 16'h0002);
    push_pkt(1'b0, 16'h0001);
    push_pkt(1'b1, 16'h0002);
    cmp_bytes("cont");

    // Busy timeout: transmitter never responds
    model_en = 1'b0;
    do_reset();
    s0_data = 16'h5555; s0_valid = 1'b1;
    @(negedge clk);
    chk("tmo_first", tx_start, 1);
    s0_valid = 1'b0;
    repeat (3) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tx_start && n < 20);
      chk("tmo_gap", n, 5);
      chk("tmo_data", tx_data, 8'hA5);
    end
    chk("tmo_busy", busy, 1);
    chk("tmo_count", pkt_count, 0);

    // Reset in the middle of byte 2
    model_en = 1'b1;
    do_reset();
    s1_data = 16'hABCD; s1_valid = 1'b1;
    @(negedge clk);
    s1_valid = 1'b0;
    n = 0;
    while (!(sent_q.size() == 3 && tx_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", n < 300, 1);
    repeat (2) @(negedge clk);
    chk("mid_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", pkt_count, 0);
    chk("mid_rst_data", tx_data, 8'h00);
    @(negedge clk);
    s0_data = 16'h0001; s0_valid = 1'b1;
    do_reset();
    @(negedge clk);
    s0_valid = 1'b0;
    wait_pkts("mid_done", 16'd1, 400);
    push_pkt(1'b0, 16'h0001);
    cmp_bytes("mid");

    // Counter wrap
    @(negedge clk);
    force dut.pkt_count = 16'hFFFE;
    #1 release dut.pkt_count;
    #1 chk("wrap_pre", pkt_count, 16'hFFFE);
    s0_data = 16'h00FF; s0_valid = 1'b1;
    wait_pkts("wrap_ffff", 16'hFFFF, 400);
    wait_pkts("wrap_zero", 16'h0000, 400);
    s0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_idle", busy, 0);

    chk("protocol", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
